// File: rtl/endstop_pkg.sv
// Shared types and widths for the endstop event collector.
package endstop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_UNLOCK  = 2'd2,
        ST_WAIT    = 2'd3
    } state_e;

    localparam int unsigned ENDSTOP_CHAN_W = 3;
    localparam int unsigned ENDSTOP_POS_W  = 32;

endpackage

// File: rtl/endstop_events_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping N-1 -> 0.
module rr_pick
    import endstop_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0]                req,
    input  logic [ENDSTOP_CHAN_W-1:0]   last,
    output logic [ENDSTOP_CHAN_W-1:0]   grant_idx,
    output logic                        any
);

    int unsigned  cand;
    logic [N-1:0] req_rot;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        req_rot   = '0;
        // k = N wraps back onto `last` itself, so a lone requester at `last` is still served
        for (int unsigned k = 1; k <= N; k++) begin
            cand    = (32'(last) + k) % N;
            req_rot = req >> cand;
            if (!any && req_rot[0]) begin
                any       = 1'b1;
                grant_idx = ENDSTOP_CHAN_W'(cand);
            end
        end
    end

endmodule

// File: rtl/endstop_events.sv
// Collects locked endstop change reports, raises a sticky abort on trigger-level
// hits, and serialises reports into a valid/ready event stream.
module endstop_events
    import endstop_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N-1:0]                ch_sig,
    input  logic [N-1:0]                ch_changed,
    input  logic [ENDSTOP_POS_W*N-1:0]  ch_pos,
    output logic [N-1:0]                ch_unlock,
    input  logic [N-1:0]                enable,
    input  logic [N-1:0]                trig_level,
    input  logic                        abort_clear,
    output logic                        abort,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [2:0]                  evt_chan,
    output logic                        evt_level,
    output logic [31:0]                 evt_pos,
    output logic [15:0]                 evt_count
);

    state_e                     state_q, state_d;
    logic [ENDSTOP_CHAN_W-1:0]  cur_q, cur_d;
    logic [ENDSTOP_CHAN_W-1:0]  last_q, last_d;
    logic                       level_q, level_d;
    logic [ENDSTOP_POS_W-1:0]   pos_q, pos_d;
    logic [15:0]                count_q, count_d;
    logic                       abort_q, abort_d;
    logic                       valid_q, valid_d;
    logic [N-1:0]               unlock_q, unlock_d;

    logic [ENDSTOP_CHAN_W-1:0]  grant;
    logic                       any_pending;
    logic                       sel_sig;
    logic                       sel_en;
    logic [ENDSTOP_POS_W-1:0]   sel_pos;
    logic                       cur_changed;
    logic [N-1:0]               grant_oh;
    logic [N-1:0]               cur_oh;
    logic                       abort_set;

    rr_pick #(.N(N)) u_pick (
        .req       (ch_changed),
        .last      (last_q),
        .grant_idx (grant),
        .any       (any_pending)
    );

    always_comb begin
        sel_sig     = 1'b0;
        sel_en      = 1'b0;
        sel_pos     = '0;
        cur_changed = 1'b0;
        grant_oh    = '0;
        cur_oh      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == ENDSTOP_CHAN_W'(i)) begin
                sel_sig     = ch_sig[i];
                sel_en      = enable[i];
                sel_pos     = ch_pos[i*ENDSTOP_POS_W +: ENDSTOP_POS_W];
                grant_oh[i] = 1'b1;
            end
            if (cur_q == ENDSTOP_CHAN_W'(i)) begin
                cur_changed = ch_changed[i];
                cur_oh[i]   = 1'b1;
            end
        end
    end

    assign abort_set = |(enable & ch_changed & ~(ch_sig ^ trig_level));

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        level_d  = level_q;
        pos_d    = pos_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        unlock_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    cur_d   = grant;
                    last_d  = grant;
                    level_d = sel_sig;
                    pos_d   = sel_pos;
                    // disabled channels are re-armed silently, no event
                    if (sel_en) begin
                        state_d = ST_PRESENT;
                        valid_d = 1'b1;
                    end else begin
                        state_d  = ST_UNLOCK;
                        unlock_d = grant_oh;
                    end
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    count_d  = count_q + 16'd1;
                    state_d  = ST_UNLOCK;
                    unlock_d = cur_oh;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_UNLOCK: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!cur_changed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // set has priority over clear
        if (abort_set)        abort_d = 1'b1;
        else if (abort_clear) abort_d = 1'b0;
        else                  abort_d = abort_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            last_q   <= ENDSTOP_CHAN_W'(N - 1);
            level_q  <= 1'b0;
            pos_q    <= '0;
            count_q  <= '0;
            abort_q  <= 1'b0;
            valid_q  <= 1'b0;
            unlock_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            level_q  <= level_d;
            pos_q    <= pos_d;
            count_q  <= count_d;
            abort_q  <= abort_d;
            valid_q  <= valid_d;
            unlock_q <= unlock_d;
        end
    end

    assign ch_unlock = unlock_q;
    assign abort     = abort_q;
    assign evt_valid = valid_q;
    assign evt_chan  = cur_q;
    assign evt_level = level_q;
    assign evt_pos   = pos_q;
    assign evt_count = count_q;

endmodule

// File: tb/tb_endstop_events.sv
// Directed self-checking bench for endstop_events with a minimal debouncer model
// (ch_changed drops the cycle after its unlock pulse is seen).
module tb_endstop_events;

    localparam int unsigned N = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    ch_sig;
    logic [N-1:0]    ch_changed;
    logic [32*N-1:0] ch_pos;
    logic [N-1:0]    ch_unlock;
    logic [N-1:0]    enable;
    logic [N-1:0]    trig_level;
    logic            abort_clear;
    logic            abort;
    logic            evt_valid;
    logic            evt_ready;
    logic [2:0]      evt_chan;
    logic            evt_level;
    logic [31:0]     evt_pos;
    logic [15:0]     evt_count;

    int vectors = 0;
    int miscompares = 0;

    endstop_events #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_sig      (ch_sig),
        .ch_changed  (ch_changed),
        .ch_pos      (ch_pos),
        .ch_unlock   (ch_unlock),
        .enable      (enable),
        .trig_level  (trig_level),
        .abort_clear (abort_clear),
        .abort       (abort),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_level   (evt_level),
        .evt_pos     (evt_pos),
        .evt_count   (evt_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ch_changed = ch_changed & ~ch_unlock;
    endtask

    task automatic set_pos(input int idx, input logic [31:0] val);
        ch_pos[idx*32 +: 32] = val;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ch_sig      = '0;
        ch_changed  = '0;
        ch_pos      = '0;
        enable      = 6'h3F;
        trig_level  = 6'h3F;
        abort_clear = 1'b0;
        evt_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({abort, evt_valid, evt_chan, evt_level, evt_pos, evt_count, ch_unlock} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got abort=%b valid=%b chan=%0d lvl=%b pos=%h cnt=%0d unl=%b, want all 0",
                     abort, evt_valid, evt_chan, evt_level, evt_pos, evt_count, ch_unlock);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        ch_sig[2] = 1'b1;
        set_pos(2, 32'h0000_1234);
        ch_changed[2] = 1'b1;
        step();
        vectors++;
        if ({abort, evt_valid, evt_chan, evt_level, evt_pos, evt_count} !== {1'b1, 1'b1, 3'd2, 1'b1, 32'h1234, 16'd0}) begin
            miscompares++;
            $display("FAIL single_hit_event: got abort=%b valid=%b chan=%0d lvl=%b pos=%h cnt=%0d, want 1 1 2 1 00001234 0",
                     abort, evt_valid, evt_chan, evt_level, evt_pos, evt_count);
        end
        evt_ready = 1'b1;
        step();
        vectors++;
        if ({evt_valid, ch_unlock, evt_count} !== {1'b0, 6'b000100, 16'd1}) begin
            miscompares++;
            $display("FAIL single_hit_unlock: got valid=%b unl=%b cnt=%0d, want 0 000100 1", evt_valid, ch_unlock, evt_count);
        end
        step();
        vectors++;
        if (ch_unlock !== 6'b0) begin
            miscompares++;
            $display("FAIL single_hit_unlock_width: got unl=%b, want 000000", ch_unlock);
        end
    endtask

    task automatic test_round_robin();
        int seen_chan[$];
        int seen_cyc[$];
        int exp_chan[5] = '{0, 3, 5, 0, 3};
        do_reset();
        trig_level = '0;
        ch_sig = 6'h3F;
        evt_ready = 1'b1;
        ch_changed = 6'b101001;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (evt_valid) begin
                seen_chan.push_back(int'(evt_chan));
                seen_cyc.push_back(c);
            end
            if (seen_chan.size() == 3 && ch_changed[5] == 1'b0 && ch_changed[0] == 1'b0) ch_changed = 6'b001001;
        end
        vectors++;
        if (seen_chan.size() != 5) begin
            miscompares++;
            $display("FAIL rr_event_total: got %0d events, want 5", seen_chan.size());
        end
        for (int i = 0; i < 5 && i < seen_chan.size(); i++) begin
            vectors++;
            if (seen_chan[i] != exp_chan[i]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got chan %0d, want %0d", i, seen_chan[i], exp_chan[i]);
            end
        end
        for (int i = 1; i < 3 && i < seen_cyc.size(); i++) begin
            vectors++;
            if (seen_cyc[i] - seen_cyc[i-1] != 4) begin
                miscompares++;
                $display("FAIL rr_spacing[%0d]: got %0d cycles, want 4", i, seen_cyc[i] - seen_cyc[i-1]);
            end
        end
        vectors++;
        if (evt_count !== 16'd5 || abort !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_count: got cnt=%0d abort=%b, want 5 0", evt_count, abort);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int bad = 0;
        do_reset();
        ch_sig[1] = 1'b0;
        set_pos(1, 32'hABCD_0001);
        ch_changed[1] = 1'b1;
        step();
        set_pos(1, 32'h0);
        ch_sig[1] = 1'b1;
        trig_level = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            if ({evt_valid, evt_chan, evt_level, evt_pos, ch_unlock} !== {1'b1, 3'd1, 1'b0, 32'hABCD_0001, 6'b0}) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_stable: got %0d unstable cycles, want 0", bad);
        end
        evt_ready = 1'b1;
        step();
        vectors++;
        if ({evt_valid, ch_unlock, evt_count} !== {1'b0, 6'b000010, 16'd1}) begin
            miscompares++;
            $display("FAIL backpressure_release: got valid=%b unl=%b cnt=%0d, want 0 000010 1", evt_valid, ch_unlock, evt_count);
        end
    endtask

    task automatic test_disabled_drain();
        int valids = 0;
        int pulses = 0;
        int pulse_cyc = -1;
        int aborts = 0;
        do_reset();
        enable = 6'b101111;
        ch_sig[4] = 1'b1;
        ch_changed[4] = 1'b1;
        evt_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (evt_valid) valids++;
            if (abort) aborts++;
            if (ch_unlock == 6'b010000) begin
                pulses++;
                pulse_cyc = c;
            end else if (ch_unlock != 6'b0) pulses += 100;
        end
        vectors++;
        if (valids != 0 || aborts != 0 || evt_count !== 16'd0) begin
            miscompares++;
            $display("FAIL drain_silent: got valids=%0d aborts=%0d cnt=%0d, want 0 0 0", valids, aborts, evt_count);
        end
        vectors++;
        if (pulses != 1 || pulse_cyc != 1) begin
            miscompares++;
            $display("FAIL drain_unlock: got pulses=%0d at cycle %0d, want 1 at cycle 1", pulses, pulse_cyc);
        end
    endtask

    task automatic test_abort_clear();
        do_reset();
        ch_sig[1] = 1'b1;
        ch_changed[1] = 1'b1;
        step();
        abort_clear = 1'b1;
        step();
        abort_clear = 1'b0;
        vectors++;
        if (abort !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_set_wins: got abort=%b, want 1", abort);
        end
        evt_ready = 1'b1;
        step();
        abort_clear = 1'b1;
        step();
        abort_clear = 1'b0;
        vectors++;
        if (abort !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_cleared: got abort=%b, want 0", abort);
        end
        step();
        ch_sig[1] = 1'b0;
        ch_changed[1] = 1'b1;
        step();
        vectors++;
        if ({evt_valid, evt_chan, evt_level, abort} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL release_event: got valid=%b chan=%0d lvl=%b abort=%b, want 1 1 0 0", evt_valid, evt_chan, evt_level, abort);
        end
        step();
        vectors++;
        if ({evt_count, abort} !== {16'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL release_count: got cnt=%0d abort=%b, want 2 0", evt_count, abort);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        trig_level = '0;
        ch_sig = 6'h3F;
        set_pos(3, 32'h3333_0000);
        ch_changed[2] = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        evt_ready = 1'b0;
        ch_changed[3] = 1'b1;
        step();
        vectors++;
        if ({evt_valid, evt_chan, evt_count} !== {1'b1, 3'd3, 16'd1}) begin
            miscompares++;
            $display("FAIL mid_reset_setup: got valid=%b chan=%0d cnt=%0d, want 1 3 1", evt_valid, evt_chan, evt_count);
        end
        ch_changed[0] = 1'b1;
        ch_changed[4] = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({abort, evt_valid, evt_chan, evt_level, evt_pos, evt_count, ch_unlock} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_values: got valid=%b chan=%0d lvl=%b pos=%h cnt=%0d unl=%b, want all 0",
                     evt_valid, evt_chan, evt_level, evt_pos, evt_count, ch_unlock);
        end
        step();
        vectors++;
        if ({evt_valid, evt_chan} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_priority: got valid=%b chan=%0d, want 1 0", evt_valid, evt_chan);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_round_robin();
        test_back_to_back_backpressure();
        test_disabled_drain();
        test_abort_clear();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/endstop_events.md
# endstop_events

Downstream consumer of the per-axis endstop debouncers. Collects the locked change reports (`sig_changed`, `sig_out`, `pos_out`) of up to 8 debounce channels and raises a sticky motion-abort on trigger-level edges. Serialises reports round-robin into a single valid/ready event stream for the host register bank. Issues the one-cycle `unlock` pulse that re-arms each debouncer once its event is consumed.

## Interface
- `N`, 6, number of endstop channels, legal range 2..8

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `ch_sig`  in  N  debounced level per channel (debouncer `sig_out`)
- `ch_changed`  in  N  locked-change flag per channel (debouncer `sig_changed`)
- `ch_pos`  in  32*N  latched position per channel; channel i at bits [32i+31:32i]
- `ch_unlock`  out  N  one-cycle re-arm pulse per channel (to debouncer `unlock`)
- `enable`  in  N  channel enabled for events/abort
- `trig_level`  in  N  level of `ch_sig` that counts as "hit"
- `abort_clear`  in  1  clears `abort`
- `abort`  out  1  sticky stop request to motion core
- `evt_valid`  out  1  event presented
- `evt_ready`  in  1  host accepts event
- `evt_chan`  out  3  channel index of event
- `evt_level`  out  1  new level (`ch_sig` of channel at capture)
- `evt_pos`  out  32  latched position of channel at capture
- `evt_count`  out  16  total events delivered, wraps

## Operation
- Pending: `ch_changed[i]` high.
- FSM states, in order: IDLE, PRESENT, UNLOCK, WAIT.
- IDLE:
  - If any pending, pick the first pending index strictly after `last` (round-robin, wrapping N-1→0) and store it as `cur`.
  - Capture `ch_sig[cur]` and `ch_pos[cur]`; set `last <= cur`.
  - `enable[cur]`=1 → PRESENT; otherwise → UNLOCK (silent drain, no event).
- PRESENT:
  - `evt_valid`=1 with captured fields held stable.
  - On `evt_valid & evt_ready`: `evt_count` += 1 (mod 2^16), → UNLOCK.
- UNLOCK: `ch_unlock[cur]`=1 for exactly this one state cycle → WAIT.
- WAIT: stay until `ch_changed[cur]`=0, then → IDLE. No timeout; only reset escapes.
- Abort:
  - Set condition: any i with `enable[i] & ch_changed[i] & (ch_sig[i]==trig_level[i])`.
  - Evaluated every cycle, independent of the FSM.
  - `abort_clear` clears `abort` only when the set condition is false that cycle; set wins on a simultaneous set and clear.
- Enable changes apply from the next IDLE decision. An event already in PRESENT is still delivered.

## Timing
- Reset values:
  - `abort`=0, `evt_valid`=0, `evt_chan`=0, `evt_level`=0, `evt_pos`=0, `evt_count`=0, `ch_unlock`=0.
  - FSM=IDLE, `last`=N-1, so channel 0 has first priority.
- Reset mid-operation: return to reset values next cycle. A PRESENT event is dropped; an in-progress unlock pulse is cut.
- All outputs are registered.
- `ch_changed[i]` rises in cycle t (FSM in IDLE) → `evt_valid`=1 from t+1.
- Trigger condition true in cycle t → `abort`=1 from t+1.
- Handshake in cycle h → `evt_valid`=0 and `ch_unlock[cur]`=1 in h+1. The debouncer drops `ch_changed` in h+2, WAIT exits then, IDLE in h+3, and the next `evt_valid` is earliest in h+4.
- Disabled-channel drain: IDLE at t → unlock pulse at t+1 → IDLE at t+3.
- `evt_valid` never drops without a handshake, except on reset.
- `ch_unlock` is one-hot or zero.

## Structure
- Shared package `endstop_pkg`: FSM state enum (IDLE=0, PRESENT=1, UNLOCK=2, WAIT=3), `ENDSTOP_CHAN_W`=3, `ENDSTOP_POS_W`=32.
- Sub-module `rr_pick`:
  - Purely combinational round-robin picker.
  - Inputs: request vector N, `last` index.
  - Outputs: `grant_idx`, `any`.

## Test plan
- Single hit: reset; `enable`=6'h3F, `trig_level`=6'h3F; ch2 `ch_sig`=1, `ch_changed`=1, pos 0x00001234.
  - Response: `abort`=1 next cycle; `evt_valid`, `evt_chan`=2, `evt_level`=1, `evt_pos`=0x1234.
  - With `evt_ready` high: `ch_unlock`=6'b000100 for one cycle; `evt_count`=1.
- Round-robin: ch0, ch3, ch5 pending simultaneously with `evt_ready` held 1.
  - Response: events delivered in order 0, 3, 5, spaced 4 cycles apart.
  - Re-raise ch0 and ch3 after ch5 is served → next order 0, 3.
- Backpressure: `evt_ready`=0 for 20 cycles.
  - Response: `evt_valid` and all `evt_*` fields stable throughout; no `ch_unlock`.
- Disabled drain: `enable[4]`=0, ch4 pending.
  - Response: no `evt_valid`; `ch_unlock[4]` pulses once; `evt_count` unchanged; `abort` stays 0.
- Abort clear: `abort_clear` pulsed while ch1 still pending at trigger level → `abort` stays 1.
  - After ch1's event is consumed and `ch_changed[1]` drops, `abort_clear` → `abort`=0 next cycle.
  - ch1 pending at the opposite level (release) → event delivered, `abort` not set.
- Mid-operation reset: `reset` asserted while in PRESENT.
  - Response: all outputs reset next cycle; after reset, ch0 is served first.
